// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note record/playback controller.
package note_sequencer_pkg;

    localparam int unsigned OCT_W   = 3;
    localparam int unsigned NOTE_W  = 3;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned ENTRY_W = OCT_W + NOTE_W + LEN_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    // Stored entry, packed as {octave, note, length}
    typedef struct packed {
        logic [OCT_W-1:0]  octave;
        logic [NOTE_W-1:0] note;
        logic [LEN_W-1:0]  length;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_FETCH,
        S_NOTE,
        S_GAP
    } fsm_t;

    function automatic logic [1:0] state_code(input fsm_t s);
        case (s)
            S_IDLE:   return ST_IDLE;
            S_RECORD: return ST_RECORD;
            default:  return ST_PLAY;
        endcase
    endfunction

endpackage

// File: rtl/note_buffer.sv
// Simple dual-port note store: synchronous write, synchronous 1-cycle read.
module note_buffer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register doubles as the sounding-note holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback controller: captures key events into a buffer and replays
// them with per-note durations and a fixed silent gap.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned TICKS_PER_UNIT = 12_500_000,
    parameter int unsigned GAP_TICKS      = 1_250_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              key_valid,
    input  logic [OCT_W-1:0]  octave,
    input  logic [NOTE_W-1:0] note,
    input  logic [LEN_W-1:0]  length,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              play_valid,
    output logic [OCT_W-1:0]  play_octave,
    output logic [NOTE_W-1:0] play_note,
    output logic [ADDR_W-1:0] play_idx,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DUR_W = $clog2(16 * TICKS_PER_UNIT) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_TICKS) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    fsm_t               fsm_q, fsm_d;
    logic [CNT_W-1:0]   count_d, idx_q, idx_d, fetch_idx_c;
    logic [DUR_W-1:0]   dur_q, dur_d, dur_last_c;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               done_d, fetch_c, wr_en_c, rd_en_c;
    logic [ENTRY_W-1:0] rd_data;
    entry_t             wr_entry_c, rd_entry;

    assign wr_entry_c  = '{octave: octave, note: note, length: length};
    assign rd_entry    = entry_t'(rd_data);
    assign play_octave = rd_entry.octave;
    assign play_note   = rd_entry.note;
    assign play_idx    = idx_q[ADDR_W-1:0];
    assign dur_last_c  = DUR_W'((32'(rd_entry.length) + 32'd1) * 32'(TICKS_PER_UNIT) - 32'd1);

    note_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr (count[ADDR_W-1:0]),
        .wr_data (wr_entry_c),
        .rd_en   (rd_en_c),
        .rd_addr (fetch_idx_c[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // Next-state logic; the last gap cycle fetches the next entry so notes
    // are separated by exactly GAP_TICKS silent cycles.
    always_comb begin
        fsm_d       = fsm_q;
        count_d     = count;
        idx_d       = idx_q;
        dur_d       = dur_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        fetch_c     = 1'b0;
        fetch_idx_c = idx_q;
        wr_en_c     = 1'b0;
        rd_en_c     = 1'b0;

        if (stop) begin
            fsm_d = S_IDLE;
            dur_d = '0;
            gap_d = '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (rec_start) begin
                        fsm_d   = S_RECORD;
                        count_d = '0;
                    end else if (play_start) begin
                        fsm_d = S_FETCH;
                        idx_d = '0;
                    end
                end
                S_RECORD: begin
                    if (rec_start) begin
                        count_d = '0;
                    end else if (key_valid && !full) begin
                        wr_en_c = 1'b1;
                        count_d = count + CNT_W'(1);
                    end
                end
                default: begin
                    if (play_start) begin
                        fsm_d = S_FETCH;
                        idx_d = '0;
                        dur_d = '0;
                        gap_d = '0;
                    end else begin
                        case (fsm_q)
                            S_FETCH: fetch_c = 1'b1;
                            S_NOTE: begin
                                if (dur_q == dur_last_c) begin
                                    dur_d = '0;
                                    gap_d = '0;
                                    fsm_d = S_GAP;
                                end else begin
                                    dur_d = dur_q + DUR_W'(1);
                                end
                            end
                            S_GAP: begin
                                if (gap_q == GAP_LAST) begin
                                    gap_d       = '0;
                                    fetch_c     = 1'b1;
                                    fetch_idx_c = idx_q + CNT_W'(1);
                                end else begin
                                    gap_d = gap_q + GAP_W'(1);
                                end
                            end
                            default: fsm_d = S_IDLE;
                        endcase
                    end
                end
            endcase
        end

        if (fetch_c) begin
            idx_d = fetch_idx_c;
            if (fetch_idx_c == count) begin
                done_d = 1'b1;
                fsm_d  = S_IDLE;
            end else begin
                rd_en_c = 1'b1;
                dur_d   = '0;
                fsm_d   = S_NOTE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            count      <= '0;
            full       <= 1'b0;
            idx_q      <= '0;
            dur_q      <= '0;
            gap_q      <= '0;
            done       <= 1'b0;
            play_valid <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            fsm_q      <= fsm_d;
            count      <= count_d;
            full       <= (count_d == DEPTH_C);
            idx_q      <= idx_d;
            dur_q      <= dur_d;
            gap_q      <= gap_d;
            done       <= done_d;
            play_valid <= (fsm_d == S_NOTE);
            state      <= state_code(fsm_d);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized scoreboard bench for note_sequencer with a queue-based reference model.
module tb_note_sequencer;

    localparam int DEPTH = 4;
    localparam int ADDR_W = 2;
    localparam int TPU = 4;
    localparam int GAP = 2;
    localparam int BOUND = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, key_valid = 1'b0;
    logic [2:0] octave = '0, note = '0;
    logic [3:0] length = '0;
    logic [1:0] state;
    logic [ADDR_W:0] count;
    logic full, play_valid, done;
    logic [2:0] play_octave, play_note;
    logic [ADDR_W-1:0] play_idx;

    note_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TICKS_PER_UNIT(TPU), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .key_valid(key_valid), .octave(octave), .note(note),
        .length(length), .state(state), .count(count), .full(full),
        .play_valid(play_valid), .play_octave(play_octave), .play_note(play_note),
        .play_idx(play_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int oct; int nt; int len; } ent_t;
    typedef struct { int oct; int nt; int idx; int dur; bit chk_len; int gap; } note_exp_t;

    ent_t      model_buf[$];
    bit        model_rec = 1'b0;
    note_exp_t exp_q[$];
    int        done_q[$];
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected notes/done pulses as the DUT presents them
    logic      pv_d = 1'b0, done_d = 1'b0;
    int        hi_run = 0, lo_run = 0;
    note_exp_t cur;
    bit        have_cur = 1'b0;

    always @(negedge clk) begin
        if (play_valid && !pv_d) begin
            chk("note_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                chk("note_octave", int'(play_octave), cur.oct);
                chk("note_note", int'(play_note), cur.nt);
                chk("note_idx", int'(play_idx), cur.idx);
                if (cur.gap > 0) chk("gap_len", lo_run, cur.gap);
            end else begin
                have_cur = 1'b0;
            end
            hi_run = 1;
        end else if (play_valid) begin
            hi_run++;
        end
        if (!play_valid && pv_d) begin
            if (have_cur && cur.chk_len) begin
                chk("note_len", hi_run, cur.dur);
                chk("gap_hold_octave", int'(play_octave), cur.oct);
                chk("gap_hold_note", int'(play_note), cur.nt);
            end
            have_cur = 1'b0;
            lo_run = 0;
        end
        if (!play_valid) lo_run++;
        if (done) begin
            chk("done_expected", int'(done_q.size() > 0), 1);
            chk("done_width", int'(done_d), 0);
            if (done_q.size() > 0) begin
                int g;
                g = done_q.pop_front();
                if (g > 0) chk("done_gap", lo_run, g);
            end
        end
        pv_d   = play_valid;
        done_d = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rec();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        model_rec = 1'b1;
        model_buf.delete();
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
        model_rec = 1'b0;
    endtask

    task automatic key(input int o, input int n, input int l);
        octave = 3'(o); note = 3'(n); length = 4'(l);
        key_valid = 1'b1; tick(); key_valid = 1'b0;
        if (model_rec && model_buf.size() < DEPTH) model_buf.push_back('{o, n, l});
    endtask

    task automatic rand_key();
        key(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || state != 2'd0) && n < BOUND) begin
            tick();
            n++;
        end
        chk("drain_in_time", int'(n < BOUND), 1);
        repeat (3) tick();
    endtask

    // Expected playback derived from the model buffer
    task automatic push_playback(input int trunc_at, input bit with_done);
        for (int i = 0; i < model_buf.size(); i++) begin
            if (trunc_at >= 0 && i > trunc_at) break;
            exp_q.push_back('{model_buf[i].oct, model_buf[i].nt, i,
                              (model_buf[i].len + 1) * TPU, (i != trunc_at),
                              (i == 0) ? 0 : GAP});
        end
        if (with_done) done_q.push_back(model_buf.size() > 0 ? GAP + 1 : 0);
    endtask

    task automatic play_full();
        push_playback(-1, 1'b1);
        play_start = 1'b1; tick(); play_start = 1'b0;
        drain();
    endtask

    task automatic wait_note(input int idx);
        int n = 0;
        while (!(play_valid && int'(play_idx) == idx) && n < BOUND) begin
            tick();
            n++;
        end
        chk("note_reached", int'(n < BOUND), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_play_valid"}, int'(play_valid), 0);
        chk({tag, "_play_octave"}, int'(play_octave), 0);
        chk({tag, "_play_note"}, int'(play_note), 0);
        chk({tag, "_play_idx"}, int'(play_idx), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        bit seen;
        int nk;

        repeat (2) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // rec_start beats play_start in IDLE
        rec_start = 1'b1; play_start = 1'b1; tick();
        rec_start = 1'b0; play_start = 1'b0;
        model_rec = 1'b1; model_buf.delete();
        chk("prio_state", int'(state), 1);
        chk("prio_count", int'(count), 0);

        key(4, 0, 0); key(5, 3, 1); key(3, 6, 2);
        pulse_stop();
        chk("rec3_count", int'(count), 3);
        chk("rec3_full", int'(full), 0);
        chk("rec3_state", int'(state), 0);

        play_full();

        // Reset during a sounding note
        push_playback(0, 1'b0);
        play_start = 1'b1; tick(); play_start = 1'b0;
        wait_note(0);
        tick();
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        tick();
        rst = 1'b0;
        model_buf.delete();
        tick();
        done_q.push_back(0);
        play_start = 1'b1; tick(); play_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("empty_done_latency", int'(seen), 1);
        drain();

        // Overflow: fifth event is dropped
        pulse_rec();
        repeat (5) rand_key();
        chk("ovf_count", int'(count), DEPTH);
        chk("ovf_full", int'(full), 1);
        pulse_stop();
        play_full();

        // Abort during the second note, then replay from entry 0
        push_playback(1, 1'b0);
        play_start = 1'b1; tick(); play_start = 1'b0;
        wait_note(1);
        tick();
        pulse_stop();
        chk("abort_play_valid", int'(play_valid), 0);
        chk("abort_state", int'(state), 0);
        chk("abort_play_idx", int'(play_idx), 1);
        drain();
        play_full();

        // stop beats play_start in RECORD
        pulse_rec();
        stop = 1'b1; play_start = 1'b1; tick();
        stop = 1'b0; play_start = 1'b0;
        model_rec = 1'b0;
        chk("stop_prio_state", int'(state), 0);
        chk("stop_prio_count", int'(count), 0);

        // Random record/play rounds, including stray key events in IDLE
        for (int r = 0; r < 4; r++) begin
            pulse_rec();
            nk = int'($urandom_range(0, 5));
            for (int k = 0; k < nk; k++) begin
                rand_key();
                repeat ($urandom_range(0, 2)) tick();
            end
            pulse_stop();
            rand_key();
            chk("rand_count", int'(count), model_buf.size());
            chk("rand_full", int'(full), int'(model_buf.size() == DEPTH));
            play_full();
        end

        chk("leftover_notes", exp_q.size(), 0);
        chk("leftover_done", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
